// File: rtl/seq_restoring_div_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The requester drives start and the operands; the divider drives status and
// the registered results.
interface seq_restoring_div_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// IDLE accepts start, RUN performs WIDTH shift/trial-subtract iterations,
// DONE presents a one-cycle done pulse. A zero divisor skips RUN entirely and
// reports quotient all-ones, remainder = dividend and div_by_zero.
// Results are registered and only change on the edge that enters DONE.
module seq_restoring_div #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_restoring_div_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    // The partial remainder is always below the divisor between iterations,
    // so only its low WIDTH bits need storing; the extra bit lives in the
    // trial subtraction inside f_restore_step.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor, keep the difference if it did not
    // borrow, and shift the resulting quotient bit into the working quotient.
    function automatic logic [2*WIDTH-1:0] f_restore_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] dvsr
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] d;
        t = {rem, q[WIDTH-1]};
        d = t - {1'b0, dvsr};
        if (!d[WIDTH]) begin
            return {d[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        end
        return {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    // Next partial remainder and working quotient for the current iteration.
    always_comb begin
        {w_rem_nxt, w_q_nxt} = f_restore_step(r_rem, r_q, r_dvsr);
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_dvsr      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvsr <= bus.divisor;
                        if (bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= bus.dividend;
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_quotient  <= w_q_nxt;
                        r_remainder <= w_rem_nxt;
                        r_dbz       <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div (WIDTH=4). Expected results come
// from plain / and % with the zero-divisor rule applied.
module tb_seq_restoring_div;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   dn;

    seq_restoring_div_if #(.WIDTH(W)) bus ();

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and count done pulses seen there.
    task automatic tick();
        @(negedge clk);
        if (bus.done) dn++;
    endtask

    // One complete divide with a single-cycle start pulse; called at a
    // falling edge with the divider idle. Operands are scrambled while busy.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        int          lat;
        int          busyn;
        int          ia;
        int          ib;
        int          eq;
        int          er;
        int          edz;
        ia  = int'(a);
        ib  = int'(b);
        edz = (ib == 0) ? 1 : 0;
        eq  = (ib == 0) ? 15 : ia / ib;
        er  = (ib == 0) ? ia : ia % ib;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        lat   = 1;
        busyn = 0;
        while (1) begin
            if (bus.busy) busyn++;
            if (bus.done || lat >= 20) break;
            bus.dividend = 4'($urandom_range(0, 15));
            bus.divisor  = 4'($urandom_range(0, 15));
            tick();
            lat++;
        end
        chk($sformatf("lat %0d/%0d", ia, ib), 32'(lat), 32'((ib == 0) ? 1 : W + 1));
        chk($sformatf("busy_cycles %0d/%0d", ia, ib), 32'(busyn), 32'((ib == 0) ? 1 : W + 1));
        chk($sformatf("quot %0d/%0d", ia, ib), 32'(bus.quotient), 32'(eq));
        chk($sformatf("rem %0d/%0d", ia, ib), 32'(bus.remainder), 32'(er));
        chk($sformatf("dbz %0d/%0d", ia, ib), 32'(bus.div_by_zero), 32'(edz));
        tick();
        chk($sformatf("done_once %0d/%0d", ia, ib), 32'(bus.done), 32'(0));
        chk($sformatf("idle_after %0d/%0d", ia, ib), 32'(bus.busy), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int cnt;
        int ra;
        int rb;
        logic [7:0] iv;
        logic [3:0] ea;
        logic [3:0] eb;
        int eq;
        int er;
        n_chk  = 0;
        n_fail = 0;
        dn     = 0;
        rst    = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_quot", 32'(bus.quotient), 32'(0));
        chk("rst_rem", 32'(bus.remainder), 32'(0));
        chk("rst_dbz", 32'(bus.div_by_zero), 32'(0));
        rst = 1'b0;
        tick();

        // Directed cases including the boundaries and divide-by-zero.
        run_op(4'd13, 4'd3);
        run_op(4'd9, 4'd0);
        run_op(4'd15, 4'd1);
        run_op(4'd3, 4'd7);
        run_op(4'd0, 4'd5);
        run_op(4'd15, 4'd15);

        // Start pulses during RUN and during DONE must be ignored.
        d0 = dn;
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd2;
        tick();
        bus.start = 1'b0;
        cnt = 3;
        while (!bus.done && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("ign_lat", 32'(cnt), 32'(W + 1));
        chk("ign_quot", 32'(bus.quotient), 32'(3));
        chk("ign_rem", 32'(bus.remainder), 32'(2));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign_done_busy", 32'(bus.busy), 32'(0));
        chk("ign_done_quot", 32'(bus.quotient), 32'(3));
        repeat (8) tick();
        chk("ign_done_pulses", 32'(dn - d0), 32'(1));

        // Asynchronous reset in the middle of 11/2.
        bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("arst_quot", 32'(bus.quotient), 32'(0));
        chk("arst_rem", 32'(bus.remainder), 32'(0));
        chk("arst_busy", 32'(bus.busy), 32'(0));
        chk("arst_done", 32'(bus.done), 32'(0));
        chk("arst_dbz", 32'(bus.div_by_zero), 32'(0));
        d0 = dn;
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("arst_no_done", 32'(dn - d0), 32'(0));
        run_op(4'd11, 4'd2);

        // Randomized operations with random idle gaps.
        repeat (40) begin
            ra = int'($urandom_range(0, 15));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            run_op(4'(ra), 4'(rb));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Exhaustive sweep with start held high; operands for the next op are
        // presented as soon as the previous one reports done.
        d0 = dn;
        bus.start    = 1'b1;
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
        for (int i = 0; i < 256; i++) begin
            iv  = 8'(i);
            ea  = iv[7:4];
            eb  = iv[3:0];
            eq  = (eb == 0) ? 15 : int'(ea) / int'(eb);
            er  = (eb == 0) ? int'(ea) : int'(ea) % int'(eb);
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!bus.done && cnt < 20);
            chk($sformatf("exh_gap %0d/%0d", ea, eb), 32'(cnt),
                32'(((eb == 0) ? 1 : W + 1) + ((i > 0) ? 1 : 0)));
            chk($sformatf("exh_quot %0d/%0d", ea, eb), 32'(bus.quotient), 32'(eq));
            chk($sformatf("exh_rem %0d/%0d", ea, eb), 32'(bus.remainder), 32'(er));
            chk($sformatf("exh_dbz %0d/%0d", ea, eb), 32'(bus.div_by_zero), 32'((eb == 0) ? 1 : 0));
            if (i < 255) begin
                iv = 8'(i + 1);
                bus.dividend = iv[7:4];
                bus.divisor  = iv[3:0];
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (8) tick();
        chk("exh_done_pulses", 32'(dn - d0), 32'(256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
